// File: rtl/iis_tx_feeder.sv
// iis_tx_feeder: buffers signed stereo pairs in a small FIFO and hands one
// pair to the I2S transmitter per txdata_rd pulse. Start-up waits for a
// prefill level, an underrun mutes and re-prefills, and disabling playback
// drains whatever is still buffered before returning to idle.
module iis_tx_feeder #(
    parameter int DW      = 32,
    parameter int DEPTH   = 8,
    parameter int PREFILL = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [DW-1:0]            in_l,
    input  logic [DW-1:0]            in_r,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     txdata_rd,
    output logic [DW-1:0]            txdata_l,
    output logic [DW-1:0]            txdata_r,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              underrun_cnt,
    input  logic                     underrun_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREFILL = 2'd1,
        S_RUN     = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [LW-1:0]     level_reg;
    logic [15:0]       cnt_reg;

    logic              push;
    logic              pop;
    logic              underrun;
    logic              flush;
    logic              level_zero;

    // Per-channel input data, indexed 0 = left, 1 = right.
    logic [DW-1:0]     chan_in [2];

    assign chan_in[0]  = in_l;
    assign chan_in[1]  = in_r;
    assign level_zero  = (level_reg == '0);

    // Upstream may push only while the FIFO is being filled or played and has room.
    assign in_ready = ((state_reg == S_PREFILL) || (state_reg == S_RUN)) && (level_reg < DEPTH_L);
    // A flush in the same cycle discards any handshake so the FIFO ends empty.
    assign push     = in_valid && in_ready && !flush;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode plus pop/underrun/flush strobes.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        underrun   = 1'b0;
        flush      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // FIFO is kept empty while idle.
                flush = 1'b1;
                if (en) begin
                    state_next = S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (!en) begin
                    flush      = 1'b1;
                    state_next = S_IDLE;
                end else if (level_reg >= PREFILL_L) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // A pop coincident with en dropping is still honoured; an empty
                // read coincident with en dropping is just a drain-to-idle case
                // and is not counted as an underrun.
                if (txdata_rd) begin
                    if (!level_zero) begin
                        pop = 1'b1;
                    end else if (en) begin
                        underrun = 1'b1;
                    end
                end
                if (!en) begin
                    state_next = S_DRAIN;
                end else if (underrun) begin
                    state_next = S_PREFILL;
                end
            end
            S_DRAIN: begin
                if (txdata_rd && !level_zero) begin
                    pop = 1'b1;
                end
                if (en) begin
                    state_next = S_RUN;
                end else if (txdata_rd && level_zero) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_ONE;
                2'b01:   level_reg <= level_reg - LVL_ONE;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Saturating underrun counter; a clear overrides a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (underrun_clr) begin
            cnt_reg <= '0;
        end else if (underrun && (cnt_reg != 16'hFFFF)) begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

    // One storage array and one output register per channel.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [DW-1:0] mem [0:DEPTH-1];
            logic [DW-1:0] txdata_reg;

            // Sample storage write port; contents need no reset.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= chan_in[gi];
                end
            end

            // Registered read: every txdata_rd loads either the head sample or silence.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    txdata_reg <= '0;
                end else if (txdata_rd) begin
                    txdata_reg <= pop ? mem[rd_ptr_reg] : '0;
                end
            end
        end
    endgenerate

    assign txdata_l     = g_chan[0].txdata_reg;
    assign txdata_r     = g_chan[1].txdata_reg;
    assign state        = state_reg;
    assign level        = level_reg;
    assign underrun_cnt = cnt_reg;

endmodule

// File: tb/tb_iis_tx_feeder.sv
// Directed bench for iis_tx_feeder: reset, prefill/start, full and concurrent
// push/pop, underrun and clear, drain, and an asynchronous mid-run reset.
module tb_iis_tx_feeder;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] in_l;
    logic [DW-1:0] in_r;
    logic          in_valid;
    logic          in_ready;
    logic          txdata_rd;
    logic [DW-1:0] txdata_l;
    logic [DW-1:0] txdata_r;
    logic [1:0]    state;
    logic [3:0]    level;
    logic [15:0]   underrun_cnt;
    logic          underrun_clr;

    int n_cmp = 0;
    int n_mis = 0;

    iis_tx_feeder #(.DW(DW), .DEPTH(8), .PREFILL(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .in_l         (in_l),
        .in_r         (in_r),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .txdata_rd    (txdata_rd),
        .txdata_l     (txdata_l),
        .txdata_r     (txdata_r),
        .state        (state),
        .level        (level),
        .underrun_cnt (underrun_cnt),
        .underrun_clr (underrun_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] pr(input int l, input int r);
        return {l[31:0], r[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int l, input int r);
        in_l     = l[DW-1:0];
        in_r     = r[DW-1:0];
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // One-cycle read pulse followed by one idle cycle.
    task automatic rd_pulse();
        txdata_rd = 1'b1;
        step();
        txdata_rd = 1'b0;
        step();
    endtask

    // Sequence run right after reset release with en high.
    task automatic start_seq(input string pfx);
        step();
        chk({pfx, "_state_prefill"}, 64'(state), 64'd1);
        push(1, -1);
        push(2, -2);
        push(3, -3);
        chk({pfx, "_state_hold"}, 64'(state), 64'd1);
        chk({pfx, "_level3"}, 64'(level), 64'd3);
        rd_pulse();
        chk({pfx, "_rd_prefill_mute"}, {txdata_l, txdata_r}, 64'd0);
        chk({pfx, "_level3_nopop"}, 64'(level), 64'd3);
        push(4, -4);
        chk({pfx, "_state_still_prefill"}, 64'(state), 64'd1);
        chk({pfx, "_level4"}, 64'(level), 64'd4);
        step();
        chk({pfx, "_state_run"}, 64'(state), 64'd2);
        rd_pulse();
        chk({pfx, "_first_pair"}, {txdata_l, txdata_r}, pr(1, -1));
        chk({pfx, "_level_after_pop"}, 64'(level), 64'd3);
    endtask

    initial begin
        rst_n        = 1'b0;
        en           = 1'b1;
        in_valid     = 1'b1;
        in_l         = 32'd5;
        in_r         = 32'd6;
        txdata_rd    = 1'b0;
        underrun_clr = 1'b0;

        // Scenario 1: reset
        #2;
        chk("rst_txdata", {txdata_l, txdata_r}, 64'd0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_cnt", 64'(underrun_cnt), 64'd0);
        step();
        step();
        chk("rst_held_state", 64'(state), 64'd0);
        chk("rst_held_level", 64'(level), 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Scenario 2: prefill and start
        start_seq("s2");

        // Scenario 3: full, overflow ignored, concurrent push/pop
        push(5, -5);
        push(6, -6);
        push(7, -7);
        push(8, -8);
        push(9, -9);
        chk("full_level8", 64'(level), 64'd8);
        chk("full_in_ready0", 64'(in_ready), 64'd0);
        push(100, -100);
        chk("full_9th_ignored", 64'(level), 64'd8);
        rd_pulse();
        chk("pop_2", {txdata_l, txdata_r}, pr(2, -2));
        chk("pop_2_level", 64'(level), 64'd7);
        rd_pulse();
        chk("pop_3", {txdata_l, txdata_r}, pr(3, -3));
        rd_pulse();
        chk("pop_4", {txdata_l, txdata_r}, pr(4, -4));
        chk("level5", 64'(level), 64'd5);
        in_l      = 32'd10;
        in_r      = -32'sd10;
        in_valid  = 1'b1;
        txdata_rd = 1'b1;
        step();
        in_valid  = 1'b0;
        txdata_rd = 1'b0;
        chk("concurrent_head", {txdata_l, txdata_r}, pr(5, -5));
        chk("concurrent_level", 64'(level), 64'd5);
        step();

        // Scenario 4: empty the FIFO, then underrun
        rd_pulse();
        chk("pop_6", {txdata_l, txdata_r}, pr(6, -6));
        rd_pulse();
        chk("pop_7", {txdata_l, txdata_r}, pr(7, -7));
        rd_pulse();
        chk("pop_8", {txdata_l, txdata_r}, pr(8, -8));
        rd_pulse();
        chk("pop_9", {txdata_l, txdata_r}, pr(9, -9));
        rd_pulse();
        chk("pop_10", {txdata_l, txdata_r}, pr(10, -10));
        chk("empty_level", 64'(level), 64'd0);
        chk("empty_still_run", 64'(state), 64'd2);
        push(7, -7);
        chk("one_entry", 64'(level), 64'd1);
        rd_pulse();
        chk("last_entry", {txdata_l, txdata_r}, pr(7, -7));
        rd_pulse();
        chk("underrun_mute", {txdata_l, txdata_r}, 64'd0);
        chk("underrun_cnt1", 64'(underrun_cnt), 64'd1);
        chk("underrun_state", 64'(state), 64'd1);
        push(11, -11);
        push(12, -12);
        push(13, -13);
        push(14, -14);
        step();
        chk("rerun_state", 64'(state), 64'd2);
        rd_pulse();
        chk("pop_11", {txdata_l, txdata_r}, pr(11, -11));
        rd_pulse();
        rd_pulse();
        rd_pulse();
        chk("pop_14", {txdata_l, txdata_r}, pr(14, -14));
        chk("cnt_before_clr", 64'(underrun_cnt), 64'd1);
        underrun_clr = 1'b1;
        txdata_rd    = 1'b1;
        step();
        underrun_clr = 1'b0;
        txdata_rd    = 1'b0;
        chk("clr_wins", 64'(underrun_cnt), 64'd0);
        chk("clr_underrun_state", 64'(state), 64'd1);
        chk("clr_underrun_mute", {txdata_l, txdata_r}, 64'd0);
        step();

        // Scenario 5: drain
        push(21, -21);
        push(22, -22);
        push(23, -23);
        push(24, -24);
        step();
        rd_pulse();
        chk("pop_21", {txdata_l, txdata_r}, pr(21, -21));
        en = 1'b0;
        step();
        chk("drain_state", 64'(state), 64'd3);
        chk("drain_in_ready", 64'(in_ready), 64'd0);
        in_l     = 32'd99;
        in_r     = 32'd98;
        in_valid = 1'b1;
        rd_pulse();
        chk("drain_22", {txdata_l, txdata_r}, pr(22, -22));
        rd_pulse();
        chk("drain_23", {txdata_l, txdata_r}, pr(23, -23));
        rd_pulse();
        chk("drain_24", {txdata_l, txdata_r}, pr(24, -24));
        chk("drain_no_push", 64'(level), 64'd0);
        rd_pulse();
        in_valid = 1'b0;
        chk("drain_end_mute", {txdata_l, txdata_r}, 64'd0);
        chk("drain_end_idle", 64'(state), 64'd0);
        chk("drain_no_count", 64'(underrun_cnt), 64'd0);

        // Scenario 6: asynchronous reset mid-run
        en = 1'b1;
        step();
        push(31, -31);
        push(32, -32);
        push(33, -33);
        push(34, -34);
        push(35, -35);
        push(36, -36);
        rd_pulse();
        chk("mid_pop_31", {txdata_l, txdata_r}, pr(31, -31));
        push(37, -37);
        chk("mid_level6", 64'(level), 64'd6);
        chk("mid_state_run", 64'(state), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_txdata", {txdata_l, txdata_r}, 64'd0);
        chk("async_level", 64'(level), 64'd0);
        chk("async_state", 64'(state), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b1;
        start_seq("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
